// File: rtl/ysyx_24100029_bpu_pkg.sv
// Shared types and helpers for the branch prediction unit.
// The 2-bit direction counter saturates at both ends.
package ysyx_24100029_bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    STT = 2'b11
  } bht_ctr_t;

  localparam logic [1:0] BR_TYPE_BRANCH = 2'b00;

  function automatic bht_ctr_t ctr_inc(input bht_ctr_t c);
    bht_ctr_t r;
    case (c)
      SNT:     r = WNT;
      WNT:     r = WT;
      default: r = STT;
    endcase
    return r;
  endfunction

  function automatic bht_ctr_t ctr_dec(input bht_ctr_t c);
    bht_ctr_t r;
    case (c)
      STT:     r = WT;
      WT:      r = WNT;
      default: r = SNT;
    endcase
    return r;
  endfunction

  function automatic logic ctr_taken(input bht_ctr_t c);
    return (c == WT) || (c == STT);
  endfunction

endpackage

// File: rtl/ysyx_24100029_bpu_table.sv
// BTB/BHT storage: per-entry valid/tag/target/counter, two combinational read ports, one write port.
// Counter states: SNT | strongly not taken, WNT | weakly not taken, WT | weakly taken, STT | strongly taken
module ysyx_24100029_bpu_table
  import ysyx_24100029_bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  bht_ctr_t         wr_ctr,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_valid,
  output logic [TAG_W-1:0] lk_tag,
  output logic [31:0]      lk_target,
  output bht_ctr_t         lk_ctr,
  input  logic [IDX_W-1:0] up_idx,
  output logic             up_valid,
  output logic [TAG_W-1:0] up_tag,
  output logic [31:0]      up_target,
  output bht_ctr_t         up_ctr
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  bht_ctr_t           ctr_q    [ENTRIES];

  // Flush beats a same-cycle write so a dropped update can never resurrect an entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

  assign lk_valid  = valid_q[lk_idx];
  assign lk_tag    = tag_q[lk_idx];
  assign lk_target = target_q[lk_idx];
  assign lk_ctr    = ctr_q[lk_idx];

  assign up_valid  = valid_q[up_idx];
  assign up_tag    = tag_q[up_idx];
  assign up_target = target_q[up_idx];
  assign up_ctr    = ctr_q[up_idx];

endmodule

// File: rtl/ysyx_24100029_bpu.sv
// Branch prediction unit: direct-mapped BTB + 2-bit BHT lookup on the fetch PC,
// trained by the resolved-branch bus from pipeline control.
module ysyx_24100029_bpu
  import ysyx_24100029_bpu_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IFU_pc,
  output logic        pred_res,
  output logic [31:0] pred_pc,
  input  logic        br_valid,
  input  logic        br_is_taken,
  input  logic [31:0] br_pc,
  input  logic [1:0]  br_pc_type,
  input  logic [31:0] br_npc,
  input  logic        bpu_flush
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag_pc, up_tag_pc;
  logic             lk_valid, up_valid;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic [31:0]      lk_target, up_target;
  bht_ctr_t         lk_ctr, up_ctr;
  logic             lk_hit, up_hit;
  logic             wr_en;
  logic [31:0]      wr_target;
  bht_ctr_t         wr_ctr;

  // Every type is trained as a conditional branch; the low PC bits are always zero.
  logic unused_bits;
  assign unused_bits = ^{br_pc_type, IFU_pc[1:0], br_pc[1:0]};

  assign lk_idx    = IFU_pc[IDX_W+1:2];
  assign lk_tag_pc = IFU_pc[31:IDX_W+2];
  assign up_idx    = br_pc[IDX_W+1:2];
  assign up_tag_pc = br_pc[31:IDX_W+2];

  assign lk_hit   = lk_valid && (lk_tag == lk_tag_pc);
  assign pred_res = !rst && lk_hit && ctr_taken(lk_ctr);
  assign pred_pc  = pred_res ? lk_target : IFU_pc + 32'd4;

  // Miss & not-taken leaves the table alone; a taken miss replaces whatever occupies the slot.
  assign up_hit    = up_valid && (up_tag == up_tag_pc);
  assign wr_en     = br_valid && !bpu_flush && (up_hit || br_is_taken);
  assign wr_target = br_is_taken ? br_npc : up_target;

  always_comb begin
    wr_ctr = WT;
    if (up_hit) wr_ctr = br_is_taken ? ctr_inc(up_ctr) : ctr_dec(up_ctr);
  end

  ysyx_24100029_bpu_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .flush     (bpu_flush),
    .wr_en     (wr_en),
    .wr_idx    (up_idx),
    .wr_tag    (up_tag_pc),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr),
    .lk_idx    (lk_idx),
    .lk_valid  (lk_valid),
    .lk_tag    (lk_tag),
    .lk_target (lk_target),
    .lk_ctr    (lk_ctr),
    .up_idx    (up_idx),
    .up_valid  (up_valid),
    .up_tag    (up_tag),
    .up_target (up_target),
    .up_ctr    (up_ctr)
  );

endmodule

// File: tb/tb_ysyx_24100029_bpu.sv
// Directed bench for the branch prediction unit: lookup, counter saturation, aliasing,
// same-cycle ordering, flush priority and asynchronous reset.
module tb_ysyx_24100029_bpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IFU_pc;
  logic        pred_res;
  logic [31:0] pred_pc;
  logic        br_valid;
  logic        br_is_taken;
  logic [31:0] br_pc;
  logic [1:0]  br_pc_type;
  logic [31:0] br_npc;
  logic        bpu_flush;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_24100029_bpu #(.ENTRIES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .IFU_pc      (IFU_pc),
    .pred_res    (pred_res),
    .pred_pc     (pred_pc),
    .br_valid    (br_valid),
    .br_is_taken (br_is_taken),
    .br_pc       (br_pc),
    .br_pc_type  (br_pc_type),
    .br_npc      (br_npc),
    .bpu_flush   (bpu_flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Look up pc after settling and compare both outputs.
  task automatic look(input string tag, input logic [31:0] pc, input logic res, input logic [31:0] npc);
    IFU_pc = pc;
    #1;
    chk({tag, ".res"}, {31'd0, pred_res}, {31'd0, res});
    chk({tag, ".pc"}, pred_pc, npc);
  endtask

  // One training update applied on the next edge.
  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] npc);
    br_valid = 1'b1; br_pc = pc; br_is_taken = tk; br_npc = npc;
    tick();
    br_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; IFU_pc = 32'h8000_0000; br_valid = 1'b0; br_is_taken = 1'b0;
    br_pc = '0; br_pc_type = 2'b00; br_npc = '0; bpu_flush = 1'b0;
    #12;
    look("rst_out", 32'h8000_0000, 1'b0, 32'h8000_0004);
    rst = 1'b0;
    tick();
    look("cold_miss0", 32'h8000_0000, 1'b0, 32'h8000_0004);
    look("cold_miss1", 32'h8000_0010, 1'b0, 32'h8000_0014);

    // Allocation; lookup in the update cycle still sees the old (empty) entry.
    IFU_pc = 32'h8000_0010;
    br_valid = 1'b1; br_pc = 32'h8000_0010; br_is_taken = 1'b1; br_npc = 32'h8000_0100;
    br_pc_type = 2'b11;
    #1;
    chk("alloc_same_cycle", {31'd0, pred_res}, 32'd0);
    tick();
    br_valid = 1'b0; br_pc_type = 2'b00;
    look("alloc_wt", 32'h8000_0010, 1'b1, 32'h8000_0100);

    // Counter walk: WT->WNT->SNT->SNT->WNT->WT->STT->STT->WT->WNT
    train(32'h8000_0010, 1'b0, 32'h0);
    look("ctr_wnt", 32'h8000_0010, 1'b0, 32'h8000_0014);
    train(32'h8000_0010, 1'b0, 32'h0);
    look("ctr_snt", 32'h8000_0010, 1'b0, 32'h8000_0014);
    train(32'h8000_0010, 1'b0, 32'h0);
    look("ctr_snt_sat", 32'h8000_0010, 1'b0, 32'h8000_0014);
    train(32'h8000_0010, 1'b1, 32'h8000_0300);
    look("ctr_snt_wnt", 32'h8000_0010, 1'b0, 32'h8000_0014);
    train(32'h8000_0010, 1'b1, 32'h8000_0300);
    look("ctr_wt_tgt", 32'h8000_0010, 1'b1, 32'h8000_0300);
    train(32'h8000_0010, 1'b1, 32'h8000_0300);
    look("ctr_stt", 32'h8000_0010, 1'b1, 32'h8000_0300);
    train(32'h8000_0010, 1'b1, 32'h8000_0300);
    look("ctr_stt_sat", 32'h8000_0010, 1'b1, 32'h8000_0300);
    train(32'h8000_0010, 1'b0, 32'h8000_0999);
    look("ctr_stt_wt", 32'h8000_0010, 1'b1, 32'h8000_0300);
    train(32'h8000_0010, 1'b0, 32'h0);
    look("ctr_wt_wnt", 32'h8000_0010, 1'b0, 32'h8000_0014);

    // Aliasing into index 4 replaces the occupant.
    train(32'h8000_0050, 1'b1, 32'h8000_0200);
    look("alias_new", 32'h8000_0050, 1'b1, 32'h8000_0200);
    look("alias_old", 32'h8000_0010, 1'b0, 32'h8000_0014);
    train(32'h8000_0090, 1'b0, 32'h8000_0777);
    look("miss_nt_nochg", 32'h8000_0050, 1'b1, 32'h8000_0200);
    look("miss_nt_noalloc", 32'h8000_0090, 1'b0, 32'h8000_0094);

    // Same-cycle lookup/update: old then new.
    IFU_pc = 32'h8000_0050;
    br_valid = 1'b1; br_pc = 32'h8000_0050; br_is_taken = 1'b0;
    #1;
    chk("same_cycle_old", pred_pc, 32'h8000_0200);
    tick();
    br_valid = 1'b0;
    look("same_cycle_new", 32'h8000_0050, 1'b0, 32'h8000_0054);

    // Flush drops the concurrent update and invalidates everything.
    train(32'h8000_0020, 1'b1, 32'h8000_0400);
    look("pre_flush", 32'h8000_0020, 1'b1, 32'h8000_0400);
    bpu_flush = 1'b1;
    train(32'h8000_0030, 1'b1, 32'h8000_0500);
    bpu_flush = 1'b0;
    look("flush_drop", 32'h8000_0030, 1'b0, 32'h8000_0034);
    look("flush_inval", 32'h8000_0020, 1'b0, 32'h8000_0024);

    // Asynchronous reset mid-cycle, with an update pending across the edge.
    train(32'h8000_0020, 1'b1, 32'h8000_0400);
    look("pre_rst", 32'h8000_0020, 1'b1, 32'h8000_0400);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_res", {31'd0, pred_res}, 32'd0);
    chk("rst_async_pc", pred_pc, 32'h8000_0024);
    br_valid = 1'b1; br_pc = 32'h8000_0040; br_is_taken = 1'b1; br_npc = 32'h8000_0600;
    tick();
    br_valid = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    look("post_rst_inval", 32'h8000_0020, 1'b0, 32'h8000_0024);
    look("post_rst_noupd", 32'h8000_0040, 1'b0, 32'h8000_0044);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
